// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver sampling at 16x the bit rate.
// Majority-votes samples 7/8/9 of each bit window; reports data, parity and framing events as one-cycle pulses.
module uart_rx_cfg #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic                 clkx16,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (LSB_FIRST != 0 && LSB_FIRST != 1) begin : g_bad_lsb_first
        $error("uart_rx_cfg: LSB_FIRST must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE, START, DATA, PAR, STOP, WAIT_IDLE
    } state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam bit         ODD_PAR   = (PARITY == 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic                 sync1, rxs;
    state_t               state, state_d;
    logic [3:0]           cnt, cnt_d;
    logic [3:0]           bit_cnt, bit_cnt_d;
    logic [1:0]           samp, samp_d;
    logic                 maj, maj_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 perr_lat, perr_lat_d;
    logic                 fault, fault_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 valid_d, perr_d, ferr_d;
    logic                 stop_fault;
    int                   pos;

    always_ff @(posedge clkx16 or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    always_ff @(posedge clkx16 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            samp       <= '0;
            maj        <= 1'b0;
            shreg      <= '0;
            perr_lat   <= 1'b0;
            fault      <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            bit_cnt    <= bit_cnt_d;
            samp       <= samp_d;
            maj        <= maj_d;
            shreg      <= shreg_d;
            perr_lat   <= perr_lat_d;
            fault      <= fault_d;
            data       <= data_d;
            valid      <= valid_d;
            parity_err <= perr_d;
            frame_err  <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt + 4'd1;
        bit_cnt_d  = bit_cnt;
        samp_d     = samp;
        maj_d      = maj;
        shreg_d    = shreg;
        perr_lat_d = perr_lat;
        fault_d    = fault;
        data_d     = data;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        stop_fault = fault | ~maj;
        pos        = (LSB_FIRST != 0) ? int'(bit_cnt) : DATA_BITS - 1 - int'(bit_cnt);

        // The vote is settled at count 9; every state acts on it at count 15.
        if (state != IDLE && state != WAIT_IDLE) begin
            if (cnt == 4'd7) samp_d[0] = rxs;
            if (cnt == 4'd8) samp_d[1] = rxs;
            if (cnt == 4'd9) maj_d = majority3(samp[0], samp[1], rxs);
        end

        case (state)
            IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (!rxs) begin
                    state_d    = START;
                    perr_lat_d = 1'b0;
                    fault_d    = 1'b0;
                end
            end
            START: begin
                if (cnt == 4'd15) begin
                    bit_cnt_d = '0;
                    state_d   = maj ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == 4'd15) begin
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (i == pos) shreg_d[i] = maj;
                    end
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt + 4'd1;
                    end
                end
            end
            PAR: begin
                if (cnt == 4'd15) begin
                    perr_lat_d = maj != ((^shreg) ^ ODD_PAR);
                    bit_cnt_d  = '0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (cnt == 4'd15) begin
                    if (bit_cnt == LAST_STOP) begin
                        if (stop_fault) begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_IDLE;
                        end else begin
                            data_d  = shreg;
                            valid_d = 1'b1;
                            perr_d  = perr_lat;
                            state_d = IDLE;
                        end
                    end else begin
                        fault_d   = stop_fault;
                        bit_cnt_d = bit_cnt + 4'd1;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three configurations (8N1, 8E1, 5-bit MSB-first 2 stop bits)
// driven from a frame table plus hand-written sequences for the timing corner cases.
module tb_uart_rx_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       rx0, rx1, rx2;
    logic [7:0] data0, data1;
    logic [4:0] data2;
    logic       valid0, valid1, valid2;
    logic       perr0, perr1, perr2;
    logic       ferr0, ferr1, ferr2;
    logic       busy0, busy1, busy2;

    uart_rx_cfg u0 (
        .clkx16(clk), .reset(reset), .rx(rx0), .data(data0), .valid(valid0),
        .parity_err(perr0), .frame_err(ferr0), .busy(busy0)
    );
    uart_rx_cfg #(.PARITY(2)) u1 (
        .clkx16(clk), .reset(reset), .rx(rx1), .data(data1), .valid(valid1),
        .parity_err(perr1), .frame_err(ferr1), .busy(busy1)
    );
    uart_rx_cfg #(.DATA_BITS(5), .STOP_BITS(2), .LSB_FIRST(0)) u2 (
        .clkx16(clk), .reset(reset), .rx(rx2), .data(data2), .valid(valid2),
        .parity_err(perr2), .frame_err(ferr2), .busy(busy2)
    );

    logic [2:0] vld, pe, fe, bs;
    logic [8:0] dout [3];
    assign vld = {valid2, valid1, valid0};
    assign pe  = {perr2, perr1, perr0};
    assign fe  = {ferr2, ferr1, ferr0};
    assign bs  = {busy2, busy1, busy0};
    always_comb begin
        dout[0] = {1'b0, data0};
        dout[1] = {1'b0, data1};
        dout[2] = {4'b0, data2};
    end

    int cyc = 0;
    int vcnt[3] = '{0, 0, 0};
    int pcnt[3] = '{0, 0, 0};
    int fcnt[3] = '{0, 0, 0};
    int lone[3] = '{0, 0, 0};
    int bcnt[3] = '{0, 0, 0};
    int vcyc[3] = '{0, 0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs are observed on the falling edge, half a cycle clear of the registers.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (vld[k]) begin
                vcnt[k] <= vcnt[k] + 1;
                vcyc[k] <= cyc;
            end
            if (pe[k]) pcnt[k] <= pcnt[k] + 1;
            if (pe[k] && !vld[k]) lone[k] <= lone[k] + 1;
            if (fe[k]) fcnt[k] <= fcnt[k] + 1;
            if (bs[k]) bcnt[k] <= bcnt[k] + 1;
        end
    end

    int checks = 0;
    int failures = 0;
    int start_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic b);
        case (sel)
            0:       rx0 = b;
            1:       rx1 = b;
            default: rx2 = b;
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 16-cycle bit on the line; gl_ofs >= 0 inverts that single cycle.
    task automatic bit_time(input int sel, input logic b, input int gl_ofs);
        for (int i = 0; i < 16; i++) begin
            set_rx(sel, (i == gl_ofs) ? ~b : b);
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int sel, input logic [8:0] word, input logic par_bit,
                              input logic stop_bit, input int glitch_bit);
        int nb;
        int ns;
        nb = (sel == 2) ? 5 : 8;
        ns = (sel == 2) ? 2 : 1;
        start_cyc = cyc;
        bit_time(sel, 1'b0, -1);
        for (int i = 0; i < nb; i++)
            bit_time(sel, (sel == 2) ? word[nb-1-i] : word[i], (i == glitch_bit) ? 9 : -1);
        if (sel == 1) bit_time(sel, par_bit, -1);
        for (int i = 0; i < ns; i++) bit_time(sel, stop_bit, -1);
        set_rx(sel, 1'b1);
    endtask

    typedef struct {
        int         sel;
        logic [8:0] word;
        logic       par_bit;
        logic       stop_bit;
        logic [8:0] exp_data;
        int         exp_valid;
        int         exp_perr;
        int         exp_ferr;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    int bv, bp, bf, bb;

    initial begin
        // sel 0 = 8N1, sel 1 = 8E1, sel 2 = 5 bits MSB first, 2 stop bits
        vecs[0]  = '{0, 9'h0A5, 1'b0, 1'b1, 9'h0A5, 1, 0, 0};
        vecs[1]  = '{0, 9'h000, 1'b0, 1'b1, 9'h000, 1, 0, 0};
        vecs[2]  = '{0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1, 0, 0};
        vecs[3]  = '{0, 9'h012, 1'b0, 1'b0, 9'h0FF, 0, 0, 1};
        vecs[4]  = '{1, 9'h03C, 1'b1, 1'b1, 9'h03C, 1, 1, 0};
        vecs[5]  = '{1, 9'h03C, 1'b0, 1'b1, 9'h03C, 1, 0, 0};
        vecs[6]  = '{1, 9'h001, 1'b1, 1'b1, 9'h001, 1, 0, 0};
        vecs[7]  = '{1, 9'h001, 1'b0, 1'b1, 9'h001, 1, 1, 0};
        vecs[8]  = '{1, 9'h080, 1'b1, 1'b0, 9'h001, 0, 0, 1};
        vecs[9]  = '{2, 9'h013, 1'b0, 1'b1, 9'h013, 1, 0, 0};
        vecs[10] = '{2, 9'h00A, 1'b0, 1'b1, 9'h00A, 1, 0, 0};
        vecs[11] = '{2, 9'h015, 1'b0, 1'b0, 9'h00A, 0, 0, 1};

        reset = 1'b1;
        rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
        idle(3);
        check("rst_data",  int'(data0), 0);
        check("rst_valid", int'(valid0), 0);
        check("rst_perr",  int'(perr1), 0);
        check("rst_ferr",  int'(ferr0), 0);
        check("rst_busy",  int'(bs), 0);
        reset = 1'b0;
        idle(5);

        for (int i = 0; i < NV; i++) begin
            bv = vcnt[vecs[i].sel]; bp = pcnt[vecs[i].sel]; bf = fcnt[vecs[i].sel];
            send_frame(vecs[i].sel, vecs[i].word, vecs[i].par_bit, vecs[i].stop_bit, -1);
            idle(40);
            check($sformatf("v%0d_valid", i), vcnt[vecs[i].sel] - bv, vecs[i].exp_valid);
            check($sformatf("v%0d_perr", i),  pcnt[vecs[i].sel] - bp, vecs[i].exp_perr);
            check($sformatf("v%0d_ferr", i),  fcnt[vecs[i].sel] - bf, vecs[i].exp_ferr);
            check($sformatf("v%0d_data", i),  int'(dout[vecs[i].sel]), int'(vecs[i].exp_data));
            // edges from the first edge that samples rx low to the edge raising valid
            if (i == 0) check("latency_8n1", vcyc[0] - start_cyc - 1, 162);
        end

        // Short low pulse: false start, busy for exactly one bit window
        bv = vcnt[0]; bf = fcnt[0]; bb = bcnt[0];
        rx0 = 1'b0;
        idle(4);
        rx0 = 1'b1;
        idle(40);
        check("false_start_busy",  bcnt[0] - bb, 16);
        check("false_start_valid", vcnt[0] - bv, 0);
        check("false_start_ferr",  fcnt[0] - bf, 0);

        // Back-to-back frames with no idle gap
        bv = vcnt[0]; bf = fcnt[0];
        send_frame(0, 9'h03C, 1'b0, 1'b1, -1);
        send_frame(0, 9'h0C5, 1'b0, 1'b1, -1);
        idle(40);
        check("b2b_valid", vcnt[0] - bv, 2);
        check("b2b_ferr",  fcnt[0] - bf, 0);
        check("b2b_data",  int'(data0), 8'hC5);

        // Bad stop bit followed by a line stuck low
        bv = vcnt[0]; bf = fcnt[0];
        send_frame(0, 9'h012, 1'b0, 1'b0, -1);
        rx0 = 1'b0;
        idle(40);
        check("wait_busy",  int'(busy0), 1);
        check("wait_ferr",  fcnt[0] - bf, 1);
        check("wait_valid", vcnt[0] - bv, 0);
        check("wait_data",  int'(data0), 8'hC5);
        rx0 = 1'b1;
        idle(8);
        check("wait_exit_busy", int'(busy0), 0);
        bv = vcnt[0];
        send_frame(0, 9'h055, 1'b0, 1'b1, -1);
        idle(40);
        check("after_wait_valid", vcnt[0] - bv, 1);
        check("after_wait_data",  int'(data0), 8'h55);

        // Reset in the middle of data bit 4
        bv = vcnt[0]; bp = pcnt[0]; bf = fcnt[0];
        bit_time(0, 1'b0, -1);
        for (int i = 0; i < 4; i++) bit_time(0, 1'b0, -1);
        rx0 = 1'b1;
        idle(8);
        check("pre_reset_busy", int'(busy0), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_data",  int'(data0), 0);
        check("mid_rst_data1", int'(data1), 0);
        check("mid_rst_busy",  int'(busy0), 0);
        check("mid_rst_valid", int'(valid0), 0);
        check("mid_rst_flags", int'({perr0, ferr0}), 0);
        idle(3);
        reset = 1'b0;
        idle(30);
        check("post_rst_pulses", (vcnt[0] - bv) + (pcnt[0] - bp) + (fcnt[0] - bf), 0);
        bv = vcnt[0];
        send_frame(0, 9'h0C3, 1'b0, 1'b1, -1);
        idle(40);
        check("post_rst_valid", vcnt[0] - bv, 1);
        check("post_rst_data",  int'(data0), 8'hC3);

        // Single-cycle glitch inside data bit 2, outvoted by its neighbours
        bv = vcnt[2]; bf = fcnt[2];
        send_frame(2, 9'h013, 1'b0, 1'b1, 2);
        idle(40);
        check("glitch_valid", vcnt[2] - bv, 1);
        check("glitch_ferr",  fcnt[2] - bf, 0);
        check("glitch_data",  int'(data2), 5'h13);

        check("perr_without_valid", lone[1], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
